axi_slave_mem: RTL and testbench
================================

Name: axi_slave_mem

Overview:
Synthesizable AXI3-style slave with a 32-bit word memory, sitting on the far end of the write, write-response, read-address and read-data channels of the team's AXI master BFM.
- Write and read channels run independently, each under its own state machine.
- Returns OKAY, SLVERR or DECERR responses.
- Provides the target memory for directed master tests, and a small on-chip RAM slave for integration.

Parameters:
MEM_DEPTH, 1024, memory size in 32-bit words (power of two).
BASE_ADDR, 32'h0000_0000, byte address of word 0.
WAIT_CYCLES, 2, extra cycles before each ready/valid; used only when the optional feature is compiled in.

Ports:
aclk  in  1  clock, rising edge
aresetn  in  1  asynchronous reset, active low
awid  in  4  write address ID
awadr  in  32  write byte address
awlen  in  4  burst length minus 1
awsize  in  3  burst size
awburst  in  2  burst type (00 FIXED, 01 INCR)
awlock  in  2  lock type (ignored)
awcache  in  4  cache type (ignored)
awprot  in  3  protection (ignored)
awvalid  in  1  write address valid
awready  out  1  write address ready
wid  in  4  write data ID (ignored)
wrdata  in  32  write data
wstrb  in  4  byte strobes
wlast  in  1  last write beat
wvalid  in  1  write data valid
wready  out  1  write data ready
bid  out  4  response ID
bresp  out  2  write response
bvalid  out  1  response valid
bready  in  1  response ready
arid  in  4  read address ID
araddr  in  32  read byte address
arlen  in  4  burst length minus 1
arsize  in  3  burst size
arlock  in  2  ignored
arcache  in  4  ignored
arprot  in  3  ignored
arvalid  in  1  read address valid
arready  out  1  read address ready
rid  out  4  read ID
rdata  out  32  read data
rresp  out  2  read response
rlast  out  1  last read beat
rvalid  out  1  read valid
rready  in  1  read ready

Behaviour:
- Reset: aresetn low forces all outputs to 0 immediately and both FSMs to IDLE, even mid-transfer. Memory contents are preserved.
- Ready signals are one-cycle pulses, never held high while idle, so every handshake produces a rising edge.
- Address decode: word index = (addr - BASE_ADDR) >> 2.
  - Index >= MEM_DEPTH: DECERR (2'b11).
  - Size > 3'b010, or awburst not in {00, 01}: SLVERR (2'b10).
  - Otherwise OKAY (00).
- Write FSM, W_IDLE -> W_DATA -> W_RESP:
  - W_IDLE: awvalid seen at a clock edge -> latch awid, awadr, awlen, awsize, awburst; awready = 1 on the next cycle only; go to W_DATA.
  - W_DATA: wvalid seen -> wready = 1 for one cycle. On wvalid & wready, store bytes whose wstrb bit is 1 (only if OKAY); increment beat count.
    - Address advances +4 on INCR and holds on FIXED. 32-bit arithmetic wraps; there is no 4 KB boundary check.
    - Leave when wlast = 1 or count == awlen.
    - wlast disagreeing with count == awlen sets SLVERR; the burst still completes.
  - W_RESP: bvalid = 1, bid = latched awid, bresp = accumulated status (DECERR > SLVERR > OKAY). Hold until bready = 1, then next cycle bvalid = 0 and go to W_IDLE.
- Read FSM, R_IDLE -> R_DATA -> R_GAP:
  - The read channel carries no burst type; reads are always INCR.
  - R_IDLE: arvalid seen -> latch arid, araddr, arlen, arsize; arready = 1 for one cycle; go to R_DATA.
  - R_DATA: rvalid = 1 starting the cycle after arready. rdata is the registered memory word, or 0 on error. rid = latched arid; rresp is per-beat status; rlast = 1 on beat arlen only.
    - On rvalid & rready, advance the address and load the next beat.
    - After the last beat go to R_GAP.
  - R_GAP: rvalid = 0 for exactly one cycle (guaranteed falling edge), then go to R_IDLE.
- Latency with no waits:
  - awvalid -> awready: 1 cycle.
  - arvalid -> arready: 1 cycle.
  - arready -> first rvalid: 1 cycle.
  - Last write handshake -> bvalid: 1 cycle.
- Concurrency: read and write may overlap. On a same-word same-cycle collision, read-first: the read returns the old data.

Optional Feature:
AXI_SLAVE_WAIT_STATES_EN
- Defined: a counter inserts WAIT_CYCLES idle cycles before every awready, wready, arready, first-beat rvalid and bvalid assertion. Example: WAIT_CYCLES = 2 gives awvalid -> awready in 3 cycles.
- Undefined: no counter logic; latencies are exactly as listed in Behaviour.

Test Plan:
1. Single write at 0x10 of 0xDEADBEEF, wstrb F; then read 0x10 -> bresp 00, bid = awid; rdata 0xDEADBEEF, rresp 00, rlast 1.
2. Write 0x11223344 (strb F), then 0xAABBCCDD with strb 0101 at 0x14; read 0x14 -> 0x11BB33DD.
3. INCR burst awlen = 3 at 0x20 with data 1, 2, 3, 4; read arlen = 3 -> beats 1, 2, 3, 4; rlast only on beat 4, rvalid low for one cycle afterwards.
4. Write and read at BASE_ADDR + MEM_DEPTH*4 -> bresp 11, rresp 11, rdata 0; word 0 unchanged.
5. aresetn pulsed low during W_DATA -> all outputs 0 within the same cycle; a subsequent single write/read returns OKAY with correct data.
6. Compiled with AXI_SLAVE_WAIT_STATES_EN and WAIT_CYCLES = 2 -> awready exactly 3 cycles after awvalid; compiled without it -> exactly 1 cycle.

Source files
------------

// File: rtl/axi_slave_mem.sv
// AXI3-style slave in front of a 32-bit word RAM, with independent write and read state machines.
// Optional wait-state insertion is compiled in by defining AXI_SLAVE_WAIT_STATES_EN.
`timescale 1ns/1ps
module axi_slave_mem #(
   parameter int          MEM_DEPTH   = 1024,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int          WAIT_CYCLES = 2
) (
   input  logic        aclk,
   input  logic        aresetn,
   input  logic [3:0]  awid,
   input  logic [31:0] awadr,
   input  logic [3:0]  awlen,
   input  logic [2:0]  awsize,
   input  logic [1:0]  awburst,
   input  logic [1:0]  awlock,
   input  logic [3:0]  awcache,
   input  logic [2:0]  awprot,
   input  logic        awvalid,
   output logic        awready,
   input  logic [3:0]  wid,
   input  logic [31:0] wrdata,
   input  logic [3:0]  wstrb,
   input  logic        wlast,
   input  logic        wvalid,
   output logic        wready,
   output logic [3:0]  bid,
   output logic [1:0]  bresp,
   output logic        bvalid,
   input  logic        bready,
   input  logic [3:0]  arid,
   input  logic [31:0] araddr,
   input  logic [3:0]  arlen,
   input  logic [2:0]  arsize,
   input  logic [1:0]  arlock,
   input  logic [3:0]  arcache,
   input  logic [2:0]  arprot,
   input  logic        arvalid,
   output logic        arready,
   output logic [3:0]  rid,
   output logic [31:0] rdata,
   output logic [1:0]  rresp,
   output logic        rlast,
   output logic        rvalid,
   input  logic        rready
);
   localparam int AW = $clog2(MEM_DEPTH);
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_t;
   typedef enum logic [1:0] {R_IDLE = 2'd0, R_DATA = 2'd1, R_GAP = 2'd2} r_state_t;

   function automatic logic [31:0] word_index(input logic [31:0] addr);
      return (addr - BASE_ADDR) >> 2;
   endfunction

   function automatic logic [1:0] decode(input logic [31:0] idx, input logic [2:0] size,
                                         input logic [1:0] burst);
      if (idx >= 32'(MEM_DEPTH)) return RESP_DECERR;
      else if (size > 3'b010 || burst > 2'b01) return RESP_SLVERR;
      else return RESP_OKAY;
   endfunction

   // Response encodings are ordered so the numerically larger code is the more severe one
   function automatic logic [1:0] worst(input logic [1:0] a, input logic [1:0] b);
      return (a > b) ? a : b;
   endfunction

   logic [31:0] mem [MEM_DEPTH];

   w_state_t    w_state_r, w_state_n;
   logic [3:0]  w_id_r, w_id_n, w_len_r, w_len_n, w_beat_r, w_beat_n;
   logic [31:0] w_addr_r, w_addr_n;
   logic [2:0]  w_size_r, w_size_n;
   logic [1:0]  w_burst_r, w_burst_n, w_stat_r, w_stat_n;
   logic        awready_r, awready_n, wready_r, wready_n, bvalid_r, bvalid_n;
   logic [31:0] w_idx_s;
   logic [1:0]  w_beat_st_s;
   logic        w_hs_s, w_last_s, mem_we_s, w_go_s;

   r_state_t    r_state_r, r_state_n;
   logic [3:0]  r_id_r, r_id_n, r_len_r, r_len_n, r_beat_r, r_beat_n, r_ld_beat_s;
   logic [31:0] r_addr_r, r_addr_n, r_ld_addr_s, r_ld_idx_s, rdata_r, rdata_n;
   logic [2:0]  r_size_r, r_size_n;
   logic [1:0]  rresp_r, rresp_n, r_ld_st_s;
   logic        arready_r, arready_n, rvalid_r, rvalid_n, rlast_r, rlast_n, r_ld_s, r_go_s;

   logic        unused_s;
   assign unused_s = ^{awlock, awcache, awprot, wid, arlock, arcache, arprot};

   assign w_idx_s     = word_index(w_addr_r);
   assign w_beat_st_s = decode(w_idx_s, w_size_r, w_burst_r);
   assign w_hs_s      = wvalid && wready_r;
   assign w_last_s    = wlast || (w_beat_r == w_len_r);

`ifdef AXI_SLAVE_WAIT_STATES_EN
   logic [7:0] w_cnt_r, r_cnt_r;
   logic       w_pend_s, r_pend_s;
   assign w_pend_s = (w_state_r == W_IDLE && awvalid) ||
                     (w_state_r == W_DATA && wvalid && !wready_r) ||
                     (w_state_r == W_DATA && w_hs_s && w_last_s) ||
                     (w_state_r == W_RESP && !bvalid_r);
   assign r_pend_s = (r_state_r == R_IDLE && arvalid) || (r_state_r == R_DATA && !rvalid_r);
   assign w_go_s   = (w_cnt_r >= 8'(WAIT_CYCLES));
   assign r_go_s   = (r_cnt_r >= 8'(WAIT_CYCLES));

   // Wait counters run while an assertion is pending and clear once it fires
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         w_cnt_r <= 8'd0;
         r_cnt_r <= 8'd0;
      end else begin
         w_cnt_r <= (w_pend_s && !w_go_s) ? w_cnt_r + 8'd1 : 8'd0;
         r_cnt_r <= (r_pend_s && !r_go_s) ? r_cnt_r + 8'd1 : 8'd0;
      end
   end
`else
   assign w_go_s = 1'b1;
   assign r_go_s = 1'b1;
`endif

   // Write channel next-state and next-output logic
   always_comb begin
      w_state_n = w_state_r;  w_id_n = w_id_r;     w_addr_n = w_addr_r;
      w_len_n   = w_len_r;    w_size_n = w_size_r; w_burst_n = w_burst_r;
      w_beat_n  = w_beat_r;   w_stat_n = w_stat_r; bvalid_n = bvalid_r;
      awready_n = 1'b0;       wready_n = 1'b0;     mem_we_s = 1'b0;
      case (w_state_r)
         W_IDLE: begin
            if (awvalid && w_go_s) begin
               w_id_n    = awid;    w_addr_n = awadr;  w_len_n = awlen;
               w_size_n  = awsize;  w_burst_n = awburst;
               w_beat_n  = 4'd0;    w_stat_n = RESP_OKAY;
               awready_n = 1'b1;    w_state_n = W_DATA;
            end else begin
               w_state_n = W_IDLE;
            end
         end
         W_DATA: begin
            if (w_hs_s) begin
               mem_we_s = (w_beat_st_s == RESP_OKAY);
               w_stat_n = worst(worst(w_stat_r, w_beat_st_s),
                                (wlast != (w_beat_r == w_len_r)) ? RESP_SLVERR : RESP_OKAY);
               w_beat_n = w_beat_r + 4'd1;
               w_addr_n = (w_burst_r == 2'b01) ? w_addr_r + 32'd4 : w_addr_r;
               if (w_last_s) begin
                  w_state_n = W_RESP;
                  bvalid_n  = w_go_s;
               end else begin
                  w_state_n = W_DATA;
               end
            end else begin
               wready_n = wvalid && w_go_s;
            end
         end
         W_RESP: begin
            if (!bvalid_r) begin
               bvalid_n = w_go_s;
            end else if (bready) begin
               bvalid_n  = 1'b0;
               w_state_n = W_IDLE;
            end else begin
               bvalid_n = 1'b1;
            end
         end
         default: begin
            w_state_n = W_IDLE;
            bvalid_n  = 1'b0;
         end
      endcase
   end

   // Read channel next-state logic; r_ld_s loads a beat from r_ld_addr_s into the output registers
   always_comb begin
      r_state_n = r_state_r;  r_id_n = r_id_r;     r_addr_n = r_addr_r;
      r_len_n   = r_len_r;    r_size_n = r_size_r; r_beat_n = r_beat_r;
      rvalid_n  = rvalid_r;   rlast_n = rlast_r;   rresp_n = rresp_r;
      rdata_n   = rdata_r;    arready_n = 1'b0;
      r_ld_s = 1'b0;  r_ld_addr_s = r_addr_r;  r_ld_beat_s = r_beat_r;
      case (r_state_r)
         R_IDLE: begin
            if (arvalid && r_go_s) begin
               r_id_n   = arid;   r_addr_n = araddr; r_len_n = arlen;
               r_size_n = arsize; r_beat_n = 4'd0;
               arready_n = 1'b1;  r_state_n = R_DATA;
            end else begin
               r_state_n = R_IDLE;
            end
         end
         R_DATA: begin
            if (!rvalid_r) begin
               r_ld_s = r_go_s;
            end else if (rready) begin
               if (r_beat_r == r_len_r) begin
                  rvalid_n  = 1'b0;
                  rlast_n   = 1'b0;
                  r_state_n = R_GAP;
               end else begin
                  r_ld_s      = 1'b1;
                  r_ld_addr_s = r_addr_r + 32'd4;
                  r_ld_beat_s = r_beat_r + 4'd1;
               end
            end else begin
               rvalid_n = 1'b1;
            end
         end
         R_GAP: begin
            rvalid_n  = 1'b0;
            r_state_n = R_IDLE;
         end
         default: begin
            rvalid_n  = 1'b0;
            r_state_n = R_IDLE;
         end
      endcase
      r_ld_idx_s = word_index(r_ld_addr_s);
      r_ld_st_s  = decode(r_ld_idx_s, r_size_r, 2'b01);
      if (r_ld_s) begin
         rvalid_n = 1'b1;
         r_addr_n = r_ld_addr_s;
         r_beat_n = r_ld_beat_s;
         rresp_n  = r_ld_st_s;
         rlast_n  = (r_ld_beat_s == r_len_r);
         rdata_n  = (r_ld_st_s == RESP_OKAY) ? mem[r_ld_idx_s[AW-1:0]] : 32'd0;
      end else begin
         r_ld_addr_s = r_ld_addr_s;
      end
   end

   // State and output registers for both channels
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         w_state_r <= W_IDLE;  w_id_r <= 4'd0;  w_addr_r <= 32'd0;  w_len_r <= 4'd0;
         w_size_r <= 3'd0;     w_burst_r <= 2'd0; w_beat_r <= 4'd0; w_stat_r <= 2'd0;
         awready_r <= 1'b0;    wready_r <= 1'b0;  bvalid_r <= 1'b0;
         r_state_r <= R_IDLE;  r_id_r <= 4'd0;  r_addr_r <= 32'd0;  r_len_r <= 4'd0;
         r_size_r <= 3'd0;     r_beat_r <= 4'd0;  arready_r <= 1'b0; rvalid_r <= 1'b0;
         rlast_r <= 1'b0;      rresp_r <= 2'd0;   rdata_r <= 32'd0;
      end else begin
         w_state_r <= w_state_n; w_id_r <= w_id_n;   w_addr_r <= w_addr_n; w_len_r <= w_len_n;
         w_size_r <= w_size_n;   w_burst_r <= w_burst_n; w_beat_r <= w_beat_n; w_stat_r <= w_stat_n;
         awready_r <= awready_n; wready_r <= wready_n; bvalid_r <= bvalid_n;
         r_state_r <= r_state_n; r_id_r <= r_id_n;   r_addr_r <= r_addr_n; r_len_r <= r_len_n;
         r_size_r <= r_size_n;   r_beat_r <= r_beat_n; arready_r <= arready_n; rvalid_r <= rvalid_n;
         rlast_r <= rlast_n;     rresp_r <= rresp_n;   rdata_r <= rdata_n;
      end
   end

   // RAM write port with byte strobes; a same-edge read still sees the old word
   always_ff @(posedge aclk) begin
      if (mem_we_s) begin
         for (int b = 0; b < 4; b++) begin
            if (wstrb[b]) mem[w_idx_s[AW-1:0]][8*b +: 8] <= wrdata[8*b +: 8];
         end
      end
   end

   assign awready = awready_r;
   assign wready  = wready_r;
   assign bvalid  = bvalid_r;
   assign bid     = w_id_r;
   assign bresp   = w_stat_r;
   assign arready = arready_r;
   assign rvalid  = rvalid_r;
   assign rid     = r_id_r;
   assign rdata   = rdata_r;
   assign rresp   = rresp_r;
   assign rlast   = rlast_r;
endmodule

// File: tb/tb_axi_slave_mem.sv
// Directed bench for axi_slave_mem: single, strobed, burst, error, reset and latency cases.
`timescale 1ns/1ps
module tb_axi_slave_mem;
   logic        aclk = 1'b0;
   logic        aresetn;
   logic [3:0]  awid, awlen, awcache, wid, arid, arlen, arcache, wstrb;
   logic [31:0] awadr, wrdata, araddr;
   logic [2:0]  awsize, awprot, arsize, arprot;
   logic [1:0]  awburst, awlock, arlock;
   logic        awvalid, wlast, wvalid, bready, arvalid, rready;
   logic        awready, wready, bvalid, arready, rlast, rvalid;
   logic [3:0]  bid, rid;
   logic [1:0]  bresp, rresp;
   logic [31:0] rdata;

   int n_checks = 0;
   int n_pass   = 0;
   int aw_lat, b_lat, ar_lat, cyc;
   logic [3:0]  b_id, rd_id;
   logic [1:0]  b_resp;
   logic [31:0] wq [16];
   logic [31:0] rd_data [16];
   logic [1:0]  rd_resp [16];
   logic        rd_last [16];

`ifdef AXI_SLAVE_WAIT_STATES_EN
   localparam int EXP_A_LAT = 3;
   localparam int EXP_B_LAT = 2;
`else
   localparam int EXP_A_LAT = 1;
   localparam int EXP_B_LAT = 0;
`endif

   axi_slave_mem dut (
      .aclk(aclk), .aresetn(aresetn),
      .awid(awid), .awadr(awadr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
      .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
      .wid(wid), .wrdata(wrdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
      .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arlock(arlock),
      .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
      .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
   );

   always #5 aclk = ~aclk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic axi_write(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                            input logic [1:0] burst, input logic [2:0] size, input int nbeats,
                            input logic [3:0] strb);
      int c;
      @(negedge aclk);
      awid = id; awadr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
      c = 0;
      while (awready !== 1'b1 && c < 100) begin @(negedge aclk); c++; end
      aw_lat = c;
      check("awready_seen", 32'(awready), 32'd1);
      @(negedge aclk);
      awvalid = 1'b0;
      for (int i = 0; i < nbeats; i++) begin
         wrdata = wq[i]; wstrb = strb; wlast = (i == nbeats - 1); wvalid = 1'b1;
         c = 0;
         while (wready !== 1'b1 && c < 100) begin @(negedge aclk); c++; end
         check("wready_seen", 32'(wready), 32'd1);
         @(negedge aclk);
      end
      wvalid = 1'b0; wlast = 1'b0;
      c = 0;
      while (bvalid !== 1'b1 && c < 100) begin @(negedge aclk); c++; end
      b_lat = c;
      check("bvalid_seen", 32'(bvalid), 32'd1);
      b_id = bid; b_resp = bresp;
      bready = 1'b1;
      @(negedge aclk);
      bready = 1'b0;
      check("bvalid_drop", 32'(bvalid), 32'd0);
   endtask

   task automatic axi_read(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input logic [2:0] size, input int nbeats);
      int c;
      @(negedge aclk);
      arid = id; araddr = addr; arlen = len; arsize = size; arvalid = 1'b1;
      c = 0;
      while (arready !== 1'b1 && c < 100) begin @(negedge aclk); c++; end
      ar_lat = c;
      check("arready_seen", 32'(arready), 32'd1);
      @(negedge aclk);
      arvalid = 1'b0; rready = 1'b1;
      for (int i = 0; i < nbeats; i++) begin
         c = 0;
         while (rvalid !== 1'b1 && c < 100) begin @(negedge aclk); c++; end
         check("rvalid_seen", 32'(rvalid), 32'd1);
         rd_data[i] = rdata; rd_resp[i] = rresp; rd_last[i] = rlast; rd_id = rid;
         @(negedge aclk);
      end
      rready = 1'b0;
      check("rvalid_gap", 32'(rvalid), 32'd0);
   endtask

   initial begin
      aresetn = 1'b0;
      awid = 4'd0; awadr = 32'd0; awlen = 4'd0; awsize = 3'd0; awburst = 2'd0; awlock = 2'd0;
      awcache = 4'd0; awprot = 3'd0; awvalid = 1'b0; wid = 4'd0; wrdata = 32'd0; wstrb = 4'd0;
      wlast = 1'b0; wvalid = 1'b0; bready = 1'b0; arid = 4'd0; araddr = 32'd0; arlen = 4'd0;
      arsize = 3'd0; arlock = 2'd0; arcache = 4'd0; arprot = 3'd0; arvalid = 1'b0; rready = 1'b0;
      repeat (3) @(negedge aclk);
      check("rst_awready", 32'(awready), 32'd0);
      check("rst_wready",  32'(wready),  32'd0);
      check("rst_bvalid",  32'(bvalid),  32'd0);
      check("rst_arready", 32'(arready), 32'd0);
      check("rst_rvalid",  32'(rvalid),  32'd0);
      check("rst_rdata",   rdata,        32'd0);
      aresetn = 1'b1;

      wq[0] = 32'hCAFE_F00D;
      axi_write(4'h1, 32'h0000_0000, 4'd0, 2'b01, 3'b010, 1, 4'hF);
      check("w0_bresp", 32'(b_resp), 32'd0);

      // Single write and read-back with latency checks
      wq[0] = 32'hDEAD_BEEF;
      axi_write(4'h5, 32'h0000_0010, 4'd0, 2'b01, 3'b010, 1, 4'hF);
      check("t1_aw_lat", aw_lat, EXP_A_LAT);
      check("t1_b_lat",  b_lat,  EXP_B_LAT);
      check("t1_bresp",  32'(b_resp), 32'd0);
      check("t1_bid",    32'(b_id),   32'h5);
      axi_read(4'h3, 32'h0000_0010, 4'd0, 3'b010, 1);
      check("t1_ar_lat", ar_lat, EXP_A_LAT);
      check("t1_rdata",  rd_data[0], 32'hDEAD_BEEF);
      check("t1_rresp",  32'(rd_resp[0]), 32'd0);
      check("t1_rlast",  32'(rd_last[0]), 32'd1);
      check("t1_rid",    32'(rd_id), 32'h3);

      // Byte strobes
      wq[0] = 32'h1122_3344;
      axi_write(4'h2, 32'h0000_0014, 4'd0, 2'b01, 3'b010, 1, 4'hF);
      wq[0] = 32'hAABB_CCDD;
      axi_write(4'h2, 32'h0000_0014, 4'd0, 2'b01, 3'b010, 1, 4'b0101);
      axi_read(4'h2, 32'h0000_0014, 4'd0, 3'b010, 1);
      check("t2_rdata", rd_data[0], 32'h11BB_33DD);

      // INCR burst of four
      for (int i = 0; i < 4; i++) wq[i] = 32'(i + 1);
      axi_write(4'h7, 32'h0000_0020, 4'd3, 2'b01, 3'b010, 4, 4'hF);
      check("t3_bresp", 32'(b_resp), 32'd0);
      axi_read(4'h7, 32'h0000_0020, 4'd3, 3'b010, 4);
      for (int i = 0; i < 4; i++) check("t3_rdata", rd_data[i], 32'(i + 1));
      check("t3_rlast", {28'd0, rd_last[3], rd_last[2], rd_last[1], rd_last[0]}, 32'b1000);

      // Reset in the middle of a write burst
      @(negedge aclk);
      awid = 4'h9; awadr = 32'h0000_0060; awlen = 4'd1; awsize = 3'b010; awburst = 2'b01;
      awvalid = 1'b1;
      cyc = 0;
      while (awready !== 1'b1 && cyc < 100) begin @(negedge aclk); cyc++; end
      check("t5_awready", 32'(awready), 32'd1);
      @(negedge aclk);
      awvalid = 1'b0; wrdata = 32'h1234_5678; wstrb = 4'hF; wlast = 1'b0; wvalid = 1'b1;
      cyc = 0;
      while (wready !== 1'b1 && cyc < 100) begin @(negedge aclk); cyc++; end
      check("t5_wready_pre", 32'(wready), 32'd1);
      aresetn = 1'b0;
      #1;
      check("t5_wready", 32'(wready), 32'd0);
      check("t5_awready0", 32'(awready), 32'd0);
      check("t5_bid",    32'(bid),   32'd0);
      check("t5_rdata",  rdata,      32'd0);
      check("t5_rid",    32'(rid),   32'd0);
      check("t5_rlast",  32'(rlast), 32'd0);
      wvalid = 1'b0;
      @(negedge aclk);
      aresetn = 1'b1;
      axi_read(4'h1, 32'h0000_0020, 4'd0, 3'b010, 1);
      check("t5_mem_kept", rd_data[0], 32'd1);
      wq[0] = 32'h0BAD_F00D;
      axi_write(4'h4, 32'h0000_0050, 4'd0, 2'b01, 3'b010, 1, 4'hF);
      check("t5_bresp", 32'(b_resp), 32'd0);
      axi_read(4'h4, 32'h0000_0050, 4'd0, 3'b010, 1);
      check("t5_rd", rd_data[0], 32'h0BAD_F00D);
      check("t5_rresp", 32'(rd_resp[0]), 32'd0);

      // One past the end of memory decodes to DECERR and must not alias word 0
      wq[0] = 32'h5A5A_5A5A;
      axi_write(4'h6, 32'h0000_1000, 4'd0, 2'b01, 3'b010, 1, 4'hF);
      check("t4_bresp", 32'(b_resp), 32'd3);
      axi_read(4'h6, 32'h0000_1000, 4'd0, 3'b010, 1);
      check("t4_rresp", 32'(rd_resp[0]), 32'd3);
      check("t4_rdata", rd_data[0], 32'd0);
      axi_read(4'h6, 32'h0000_0000, 4'd0, 3'b010, 1);
      check("t4_word0", rd_data[0], 32'hCAFE_F00D);

      // Oversize and reserved-burst accesses give SLVERR without touching memory
      wq[0] = 32'h0000_0055;
      axi_write(4'h3, 32'h0000_0030, 4'd0, 2'b01, 3'b010, 1, 4'hF);
      wq[0] = 32'h0000_0099;
      axi_write(4'h3, 32'h0000_0030, 4'd0, 2'b01, 3'b011, 1, 4'hF);
      check("sz_bresp", 32'(b_resp), 32'd2);
      axi_write(4'h3, 32'h0000_0030, 4'd0, 2'b10, 3'b010, 1, 4'hF);
      check("bt_bresp", 32'(b_resp), 32'd2);
      axi_read(4'h3, 32'h0000_0030, 4'd0, 3'b010, 1);
      check("sz_kept", rd_data[0], 32'h0000_0055);
      axi_read(4'h3, 32'h0000_0030, 4'd0, 3'b011, 1);
      check("sz_rresp", 32'(rd_resp[0]), 32'd2);
      check("sz_rdata", rd_data[0], 32'd0);

      // FIXED burst keeps hitting the same word
      wq[0] = 32'h4444_4444;
      axi_write(4'h8, 32'h0000_0044, 4'd0, 2'b01, 3'b010, 1, 4'hF);
      wq[0] = 32'h0000_00A0; wq[1] = 32'h0000_00B0;
      axi_write(4'h8, 32'h0000_0040, 4'd1, 2'b00, 3'b010, 2, 4'hF);
      check("fx_bresp", 32'(b_resp), 32'd0);
      axi_read(4'h8, 32'h0000_0040, 4'd1, 3'b010, 2);
      check("fx_beat0", rd_data[0], 32'h0000_00B0);
      check("fx_beat1", rd_data[1], 32'h4444_4444);

      // Early wlast is a protocol error that still ends the burst
      wq[0] = 32'h0000_0777;
      axi_write(4'hA, 32'h0000_0070, 4'd1, 2'b01, 3'b010, 1, 4'hF);
      check("wl_bresp", 32'(b_resp), 32'd2);
      check("wl_bid",   32'(b_id),   32'hA);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
